// File: rtl/seq_mul_pkg.sv
// ============================================================================
// Module      : seq_mul_pkg
// Description : Shared types and parameter checks for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mul_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_multiplier_if.sv
// ============================================================================
// Module      : seq_multiplier_if
// Description : Operand/result handshake bundle for seq_multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;
    logic                 finish;

    modport master (output start, a, b, is_signed, input  p, busy, finish);
    modport slave  (input  start, a, b, is_signed, output p, busy, finish);
endinterface

`default_nettype wire

// File: rtl/seq_mul_datapath.sv
// ============================================================================
// Module      : seq_mul_datapath
// Description : Shift-add accumulator, multiplier register and step counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_load,
    input  wire logic                 i_step,
    input  wire logic [WIDTH-1:0]     i_a,
    input  wire logic [WIDTH-1:0]     i_b,
    input  wire logic                 i_is_signed,
    output logic      [2*WIDTH-1:0]   o_prod,
    output logic                      o_last
);

    logic [WIDTH:0]   r_acc;
    logic [WIDTH:0]   r_aext;
    logic [WIDTH-1:0] r_mreg;
    logic             r_signed;
    logic [CNT_W-1:0] r_cnt;

    logic             w_sub;
    logic             w_shin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH-1:0] w_mreg_nxt;

    always_comb begin
        w_sub = r_signed && (r_cnt == CNT_W'(1));
        w_sum = r_acc;
        if (r_mreg[0]) begin
            w_sum = w_sub ? (r_acc - r_aext) : (r_acc + r_aext);
        end
        // In unsigned mode bit WIDTH is a carry, not a sign, so shift in zero.
        w_shin     = r_signed ? w_sum[WIDTH] : 1'b0;
        w_acc_nxt  = {w_shin, w_sum[WIDTH:1]};
        w_mreg_nxt = {w_sum[0], r_mreg[WIDTH-1:1]};
    end

    assign o_prod = {w_acc_nxt[WIDTH-1:0], w_mreg_nxt};
    assign o_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_aext   <= '0;
            r_mreg   <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_aext   <= {i_is_signed & i_a[WIDTH-1], i_a};
            r_mreg   <= i_b;
            r_signed <= i_is_signed;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (i_step) begin
            r_acc    <= w_acc_nxt;
            r_mreg   <= w_mreg_nxt;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module      : seq_multiplier
// Description : WIDTH-cycle shift-add multiplier with start/busy/finish handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    seq_multiplier_if.slave  bus
);

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("seq_multiplier: WIDTH out of range");
        end
    endgenerate

    state_t             r_state;
    logic               r_busy;
    logic               r_finish;
    logic [2*WIDTH-1:0] r_p;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod;

    assign w_load = (r_state == IDLE) && bus.start;
    assign w_step = (r_state == BUSY);

    seq_mul_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_a         (bus.a),
        .i_b         (bus.b),
        .i_is_signed (bus.is_signed),
        .o_prod      (w_prod),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
            r_p      <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_last) begin
                        r_p      <= w_prod;
                        r_finish <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.p      = r_p;
    assign bus.busy   = r_busy;
    assign bus.finish = r_finish;

endmodule

`default_nettype wire
